// File: rtl/prio_request_sequencer_pkg.sv
// Shared types and sizing for the priority request sequencer slice.
package prio_seq_pkg;

  localparam int unsigned N_REQ = 256;
  localparam int unsigned IDX_W = 8;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

endpackage

// File: rtl/prio_request_sequencer_enc.sv
// 256-to-8 priority encoder, combinational: highest set bit wins, o_valid = any bit set.
module priority_encoder_256to8
  import prio_seq_pkg::*;
(
  input  req_vec_t i_req,
  output idx_t     o_idx,
  output logic     o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Ascending scan: the last hit is the highest set bit.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (i_req[i]) begin
        o_idx   = i[IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_request_sequencer.sv
// Sticky pending register served highest-index-first over valid/ready.
// Optional PRIO_SEQ_OVERRUN_EN adds a sticky collision flag (overrun_flag/overrun_clr).
module prio_request_sequencer
  import prio_seq_pkg::*;
(
`ifdef PRIO_SEQ_OVERRUN_EN
  input  logic           overrun_clr,
  output logic           overrun_flag,
`endif
  input  logic           clk,
  input  logic           rst_n,
  input  req_vec_t       req_in,
  input  logic           req_load,
  output logic           out_valid,
  input  logic           out_ready,
  output idx_t           out_index,
  output logic [IDX_W:0] pending_cnt,
  output logic           busy
);

  function automatic logic [IDX_W:0] popcount(input req_vec_t v);
    logic [IDX_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) c = c + (IDX_W+1)'(v[i]);
    return c;
  endfunction

  state_t         r_state;
  req_vec_t       r_pending;
  logic           r_valid;
  idx_t           r_idx;
  logic [IDX_W:0] r_cnt;
  logic           r_busy;

  idx_t     w_enc_idx;
  logic     w_enc_any;
  logic     w_accept;
  req_vec_t w_clear;
  req_vec_t w_load;
  req_vec_t w_pending_next;

  priority_encoder_256to8 u_enc (
    .i_req   (r_pending),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_any)
  );

  assign w_accept       = r_valid & out_ready;
  assign w_clear        = w_accept ? (req_vec_t'(1) << r_idx) : '0;
  assign w_load         = req_load ? req_in : '0;
  assign w_pending_next = (r_pending & ~w_clear) | w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_cnt     <= popcount(w_pending_next);
      case (r_state)
        IDLE, GAP: begin
          if (w_enc_any) begin
            r_idx   <= w_enc_idx;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= PRESENT;
          end else begin
            r_valid <= 1'b0;
            r_busy  <= |w_pending_next;
            r_state <= IDLE;
          end
        end
        PRESENT: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_busy  <= |w_pending_next;
            r_state <= GAP;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= |w_pending_next;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef PRIO_SEQ_OVERRUN_EN
  logic r_overrun;
  logic w_collide;

  assign w_collide = req_load & (|(req_in & r_pending & ~w_clear));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overrun <= 1'b0;
    else        r_overrun <= w_collide | (r_overrun & ~overrun_clr);
  end

  assign overrun_flag = r_overrun;
`endif

  assign out_valid   = r_valid;
  assign out_index   = r_idx;
  assign pending_cnt = r_cnt;
  assign busy        = r_busy;

endmodule

// File: tb/tb_prio_request_sequencer.sv
// Self-checking bench for prio_request_sequencer: vector table, directed corner cases, random vs model.
module tb_prio_request_sequencer;
  import prio_seq_pkg::*;

  logic           clk;
  logic           rst_n;
  req_vec_t       req_in;
  logic           req_load;
  logic           out_valid;
  logic           out_ready;
  idx_t           out_index;
  logic [IDX_W:0] pending_cnt;
  logic           busy;
`ifdef PRIO_SEQ_OVERRUN_EN
  logic           overrun_clr;
  logic           overrun_flag;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  prio_request_sequencer dut (
`ifdef PRIO_SEQ_OVERRUN_EN
    .overrun_clr  (overrun_clr),
    .overrun_flag (overrun_flag),
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .req_in       (req_in),
    .req_load     (req_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .pending_cnt  (pending_cnt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    req_vec_t    req;
    logic        ready;
    logic        exp_valid;
    int unsigned exp_idx;
    int unsigned exp_cnt;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_vec_t bits4(input int a, input int b, input int c, input int d);
    req_vec_t v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  // Called at a negedge: drive inputs, advance one clock, land on the next negedge.
  task automatic step(input logic load, input req_vec_t req, input logic ready);
    req_load  = load;
    req_in    = req;
    out_ready = ready;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic v, input int unsigned idx,
                            input int unsigned cnt, input logic b);
    chk({name, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({name, ".index"}, 32'(out_index), idx);
    chk({name, ".cnt"}, 32'(pending_cnt), cnt);
    chk({name, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_load  = 1'b0;
    req_in    = '0;
    out_ready = 1'b0;
`ifdef PRIO_SEQ_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: pending set plus a single "presenting" slot.
  req_vec_t    m_pend;
  logic        m_valid;
  int unsigned m_idx;
  logic        m_ovf;

  function automatic int unsigned highest(input req_vec_t v);
    for (int i = N_REQ - 1; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input logic load, input req_vec_t req, input logic ready,
                            input logic clr);
    logic     acc;
    req_vec_t served;
    req_vec_t newp;
    acc    = m_valid && ready;
    served = '0;
    if (acc) served[m_idx] = 1'b1;
    newp   = (m_pend & ~served) | (load ? req : '0);
    m_ovf  = (load && ((req & m_pend & ~served) != '0)) || (m_ovf && !clr);
    if (m_valid) m_valid = !acc;
    else if (m_pend != '0) begin
      m_valid = 1'b1;
      m_idx   = highest(m_pend);
    end
    m_pend = newp;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset();

    chk("reset.valid", 32'(out_valid), 0);
    chk("reset.index", 32'(out_index), 0);
    chk("reset.cnt",   32'(pending_cnt), 0);
    chk("reset.busy",  32'(busy), 0);
`ifdef PRIO_SEQ_OVERRUN_EN
    chk("reset.ovf",   32'(overrun_flag), 0);
`endif

    // Single bit 0, then bits {2,10,200,255} drained at full rate.
    tbl[0]  = '{1'b1, bits4(0, -1, -1, -1),     1'b1, 1'b0, 0,   1, 1'b1};
    tbl[1]  = '{1'b0, '0,                       1'b1, 1'b1, 0,   1, 1'b1};
    tbl[2]  = '{1'b0, '0,                       1'b1, 1'b0, 0,   0, 1'b0};
    tbl[3]  = '{1'b0, '0,                       1'b1, 1'b0, 0,   0, 1'b0};
    tbl[4]  = '{1'b1, bits4(2, 10, 200, 255),   1'b1, 1'b0, 0,   4, 1'b1};
    tbl[5]  = '{1'b0, '0,                       1'b1, 1'b1, 255, 4, 1'b1};
    tbl[6]  = '{1'b0, '0,                       1'b1, 1'b0, 0,   3, 1'b1};
    tbl[7]  = '{1'b0, '0,                       1'b1, 1'b1, 200, 3, 1'b1};
    tbl[8]  = '{1'b0, '0,                       1'b1, 1'b0, 0,   2, 1'b1};
    tbl[9]  = '{1'b0, '0,                       1'b1, 1'b1, 10,  2, 1'b1};
    tbl[10] = '{1'b0, '0,                       1'b1, 1'b0, 0,   1, 1'b1};
    tbl[11] = '{1'b0, '0,                       1'b1, 1'b1, 2,   1, 1'b1};
    tbl[12] = '{1'b0, '0,                       1'b1, 1'b0, 0,   0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].load, tbl[i].req, tbl[i].ready);
      expect_out($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_idx,
                 tbl[i].exp_cnt, tbl[i].exp_busy);
    end

    // Stall on index 8; a later bit 255 must not pre-empt it.
    step(1'b1, bits4(8, -1, -1, -1), 1'b0);
    expect_out("stall.load", 1'b0, 0, 1, 1'b1);
    step(1'b0, '0, 1'b0);
    expect_out("stall.pres", 1'b1, 8, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) step(1'b1, bits4(255, -1, -1, -1), 1'b0);
      else        step(1'b0, '0, 1'b0);
      expect_out($sformatf("stall.hold%0d", i), 1'b1, 8, (i >= 2) ? 2 : 1, 1'b1);
    end
    step(1'b0, '0, 1'b1);
    expect_out("stall.acc8", 1'b0, 0, 1, 1'b1);
    step(1'b0, '0, 1'b0);
    expect_out("stall.next", 1'b1, 255, 1, 1'b1);
    step(1'b0, '0, 1'b1);
    expect_out("stall.acc255", 1'b0, 0, 0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Accept index 4 while the same bit is reloaded.
    step(1'b1, bits4(4, -1, -1, -1), 1'b0);
    step(1'b0, '0, 1'b0);
    expect_out("reacc.pres", 1'b1, 4, 1, 1'b1);
    step(1'b1, bits4(4, -1, -1, -1), 1'b1);
    expect_out("reacc.gap", 1'b0, 0, 1, 1'b1);
    step(1'b0, '0, 1'b0);
    expect_out("reacc.again", 1'b1, 4, 1, 1'b1);
    step(1'b0, '0, 1'b1);
    expect_out("reacc.done", 1'b0, 0, 0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Unknown request bus with load low must be ignored.
    req_load  = 1'b0;
    req_in    = 'x;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    expect_out("xin.idle", 1'b0, 0, 0, 1'b0);
    step(1'b1, bits4(255, -1, -1, -1), 1'b1);
    step(1'b0, '0, 1'b1);
    expect_out("xin.pres", 1'b1, 255, 1, 1'b1);
    chk("xin.noX", 32'($isunknown({out_valid, out_index, pending_cnt, busy})), 0);
    step(1'b0, '0, 1'b1);
    expect_out("xin.done", 1'b0, 0, 0, 1'b0);

    // Asynchronous reset while presenting index 200.
    step(1'b1, bits4(200, -1, -1, -1), 1'b0);
    step(1'b0, '0, 1'b0);
    expect_out("arst.pres", 1'b1, 200, 1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    expect_out("arst.clr", 1'b0, 0, 0, 1'b0);
    chk("arst.index", 32'(out_index), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef PRIO_SEQ_OVERRUN_EN
    step(1'b1, bits4(10, -1, -1, -1), 1'b0);
    chk("ovf.first", 32'(overrun_flag), 0);
    step(1'b1, bits4(10, -1, -1, -1), 1'b0);
    chk("ovf.set", 32'(overrun_flag), 1);
    step(1'b0, '0, 1'b0);
    chk("ovf.sticky", 32'(overrun_flag), 1);
    overrun_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    overrun_clr = 1'b0;
    chk("ovf.clr", 32'(overrun_flag), 0);
`endif

    // Randomised traffic against the reference model.
    do_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ovf   = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic     ld;
      logic     rdy;
      logic     clr;
      req_vec_t rq;
      ld  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 7) == 0);
      rq  = '0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) rq[$urandom_range(0, N_REQ - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) rq[m_idx] = 1'b1;
`ifdef PRIO_SEQ_OVERRUN_EN
      overrun_clr = clr;
`endif
      model_step(ld, rq, rdy, clr);
      step(ld, rq, rdy);
      expect_out($sformatf("rnd%0d", cyc), m_valid, m_idx, $countones(m_pend),
                 (m_pend != '0) || m_valid);
`ifdef PRIO_SEQ_OVERRUN_EN
      chk($sformatf("rnd%0d.ovf", cyc), 32'(overrun_flag), 32'(m_ovf));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
